piso_stream: RTL and testbench

- Parametrised successor to the fixed 75-bit piso.
- Serialises WIDTH-bit words, presented through a valid/ready handshake, onto a one-bit stream.
- A one-word holding register allows back-to-back words with no idle bit between them; bit order is selectable.
- Tracks the word index (row) within a frame of ROWS words, and flags the last bit of each word and of each frame.
- Sits between the FMA result path and the serial debug/observation link.

---
 rtl/piso_pkg.sv | 16 +
 rtl/piso_hold.sv | 44 ++++
 rtl/piso_stream.sv | 108 ++++++++++
 tb/tb_piso_stream.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// piso_stream shared types: FSM state encoding and a width helper.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/piso_hold.sv
// One-word holding register in front of the shifter.
// Emptied only when the shifter takes the word.
module piso_hold #(
  parameter int WIDTH = 75
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             take,
  output logic [WIDTH-1:0] hreg,
  output logic             hold_full,
  output logic             din_ready
);

  logic [WIDTH-1:0] hreg_q, hreg_d;
  logic             full_q, full_d;

  // take needs full_q and accept needs ~full_q, so they never coincide
  always_comb begin
    hreg_d = hreg_q;
    full_d = full_q;
    if (take) full_d = 1'b0;
    if (din_valid && !full_q) begin
      hreg_d = din;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hreg_q <= '0;
      full_q <= 1'b0;
    end else begin
      hreg_q <= hreg_d;
      full_q <= full_d;
    end
  end

  assign hreg      = hreg_q;
  assign hold_full = full_q;
  assign din_ready = ~full_q;

endmodule

// File: rtl/piso_stream.sv
// Parallel-in serial-out streamer with frame row tracking.
// Words arrive via valid/ready; bits leave one per enabled cycle.
module piso_stream
  import piso_pkg::*;
#(
  parameter int WIDTH     = 75,
  parameter int ROWS      = 14,
  parameter int MSB_FIRST = 1,
  localparam int ROW_W    = (clog2(ROWS) < 1) ? 1 : clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             tFlag,
  output logic [ROW_W-1:0] row,
  output logic             frame_end
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [WIDTH-1:0] hreg;
  logic [WIDTH-1:0] sreg_sh;
  logic             hold_full;
  logic             take;

  piso_hold #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .take      (take),
    .hreg      (hreg),
    .hold_full (hold_full),
    .din_ready (din_ready)
  );

  assign sreg_sh = (MSB_FIRST != 0) ? {sreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, sreg_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hold_full && en) begin
          take    = 1'b1;
          sreg_d  = hreg;
          cnt_d   = CNT_MAX;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          if (cnt_q != '0) begin
            sreg_d = sreg_sh;
            cnt_d  = cnt_q - 1'b1;
          end else begin
            row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            // reload straight from hreg so words run without a gap
            if (hold_full) begin
              take   = 1'b1;
              sreg_d = hreg;
              cnt_d  = CNT_MAX;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

  assign dout_valid = (state_q == SHIFT);
  assign dout = dout_valid &
    ((MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0]);
  assign tFlag     = dout_valid && (cnt_q == '0);
  assign frame_end = tFlag && (row_q == ROW_MAX);
  assign row       = row_q;

endmodule

// File: tb/tb_piso_stream.sv
// Directed bench for piso_stream: a 75-bit MSB-first instance,
// an 8-bit LSB-first instance and an 8-bit single-row instance.
module tb_piso_stream;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // instance A: WIDTH=75, ROWS=14, MSB first
  logic        a_en, a_dv, a_rdy, a_dout, a_dov, a_tf, a_fe;
  logic [74:0] a_din;
  logic [3:0]  a_row;

  // index 0: WIDTH=8, ROWS=14, LSB first; index 1: WIDTH=8, ROWS=1
  logic       en8   [2];
  logic       dv8   [2];
  logic       rdy8  [2];
  logic       dout8 [2];
  logic       dov8  [2];
  logic       tf8   [2];
  logic       fe8   [2];
  logic [7:0] din8  [2];
  logic [3:0] row8  [2];
  logic       c_row;
  assign row8[1] = {3'b000, c_row};

  piso_stream #(.WIDTH(75), .ROWS(14), .MSB_FIRST(1)) u_a (
    .clk(clk), .rst(rst), .en(a_en), .din(a_din),
    .din_valid(a_dv), .din_ready(a_rdy), .dout(a_dout),
    .dout_valid(a_dov), .tFlag(a_tf), .row(a_row),
    .frame_end(a_fe)
  );

  piso_stream #(.WIDTH(8), .ROWS(14), .MSB_FIRST(0)) u_b (
    .clk(clk), .rst(rst), .en(en8[0]), .din(din8[0]),
    .din_valid(dv8[0]), .din_ready(rdy8[0]), .dout(dout8[0]),
    .dout_valid(dov8[0]), .tFlag(tf8[0]), .row(row8[0]),
    .frame_end(fe8[0])
  );

  piso_stream #(.WIDTH(8), .ROWS(1), .MSB_FIRST(1)) u_c (
    .clk(clk), .rst(rst), .en(en8[1]), .din(din8[1]),
    .din_valid(dv8[1]), .din_ready(rdy8[1]), .dout(dout8[1]),
    .dout_valid(dov8[1]), .tFlag(tf8[1]), .row(c_row),
    .frame_end(fe8[1])
  );

  task automatic chk(input string nm, input logic [74:0] act,
                     input logic [74:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // send one word to A from IDLE and capture its 75 bits
  task automatic word75(input logic [74:0] d, output logic [74:0] cap,
                        output int lat, output int tfbad,
                        output int gaps, output logic [3:0] rw);
    cap = '0; tfbad = 0; gaps = 0; rw = '0; lat = 0;
    a_din = d;
    a_dv  = 1'b1;
    tick();
    a_dv = 1'b0;
    while (!a_dov && lat < 10) begin
      lat++;
      tick();
    end
    for (int i = 0; i < 75; i++) begin
      cap = {cap[73:0], a_dout};
      if (!a_dov) gaps++;
      if (a_tf !== (i == 74)) tfbad++;
      rw = a_row;
      tick();
    end
  endtask

  // send one word to an 8-bit instance and capture it in send order
  task automatic word8(input int k, input logic [7:0] d,
                       output logic [7:0] seq, output logic [7:0] tfm,
                       output logic [7:0] fem, output logic [3:0] rw,
                       output int gaps);
    int w;
    seq = '0; tfm = '0; fem = '0; rw = '0; gaps = 0; w = 0;
    din8[k] = d;
    dv8[k]  = 1'b1;
    tick();
    dv8[k] = 1'b0;
    while (!dov8[k] && w < 10) begin
      w++;
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      seq = {seq[6:0], dout8[k]};
      tfm = {tfm[6:0], tf8[k]};
      fem = {fem[6:0], fe8[k]};
      if (!dov8[k]) gaps++;
      rw = row8[k];
      tick();
    end
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] seq;
    logic [3:0] row_after;
  } vec_t;

  vec_t tbl [4];

  localparam logic [74:0] W0 = 75'h4204016000000000001;
  localparam logic [74:0] W1 = 75'h0004023000000000000;
  localparam logic [74:0] W2 = 75'h00040234CCCC0000000;
  localparam logic [74:0] W3 = 75'h5A5A5A5A5A5A5A5A5A5;

  initial begin
    logic [74:0]  cap;
    logic [149:0] stream;
    logic [7:0]   seq, tfm, fem;
    logic [3:0]   rw;
    logic [2:0]   snap;
    int lat, tfbad, gaps, nv, ntf, rdylow, sent, fes, fe_at, rowbad;
    bit started, acc;

    tbl[0] = '{8'hA5, 8'b10100101, 4'd1};
    tbl[1] = '{8'h01, 8'b10000000, 4'd2};
    tbl[2] = '{8'hF0, 8'b00001111, 4'd3};
    tbl[3] = '{8'h96, 8'b01101001, 4'd4};

    a_en = 1'b1; a_dv = 1'b1; a_din = W0;
    for (int k = 0; k < 2; k++) begin
      en8[k] = 1'b1; dv8[k] = 1'b1; din8[k] = 8'hFF;
    end

    // reset state, with handshakes offered during reset
    #3;
    chk("rst_outs", {a_dout, a_dov, a_tf, a_fe}, 4'b0000);
    chk("rst_row", a_row, 4'd0);
    chk("rst_rdy", a_rdy, 1'b1);
    tick();
    tick();
    chk("rst_hold_rdy", {a_rdy, a_dov}, 2'b10);
    a_dv = 1'b0; dv8[0] = 1'b0; dv8[1] = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("post_rst_idle", {a_rdy, a_dov, rdy8[0], dov8[0]}, 4'b1010);

    // test 1: single 75-bit word
    word75(W0, cap, lat, tfbad, gaps, rw);
    chk("t1_bits", cap, W0);
    chk("t1_first3", cap[74:69], 6'b100001);
    chk("t1_latency", lat, 1);
    chk("t1_tflag", tfbad, 0);
    chk("t1_gaps", gaps, 0);
    chk("t1_row_during", rw, 4'd0);
    chk("t1_row_after", {a_row, a_dov}, {4'd1, 1'b0});

    // test 2: back-to-back words with din_valid held
    a_din = W1; a_dv = 1'b1;
    sent = 0; nv = 0; ntf = 0; gaps = 0; rdylow = 0;
    started = 1'b0; stream = '0;
    for (int c = 0; c < 220 && nv < 150; c++) begin
      if (a_dov) begin
        stream = {stream[148:0], a_dout};
        nv++;
        started = 1'b1;
        if (a_tf) ntf++;
      end else if (started) begin
        gaps++;
      end
      if (sent == 1 && !a_rdy) rdylow++;
      acc = a_dv && a_rdy;
      tick();
      if (acc) begin
        sent++;
        if (sent == 1) a_din = W2;
        else a_dv = 1'b0;
      end
    end
    chk("t2_count", nv, 150);
    chk("t2_word1", stream[149:75], W1);
    chk("t2_word2", stream[74:0], W2);
    chk("t2_no_gap", gaps, 0);
    chk("t2_tflags", ntf, 2);
    chk("t2_rdy_low", rdylow, 1);
    chk("t2_row", {a_row, a_dov}, {4'd3, 1'b0});

    // test 3: table of LSB-first words on the 8-bit instance
    for (int i = 0; i < 4; i++) begin
      word8(0, tbl[i].din, seq, tfm, fem, rw, gaps);
      chk($sformatf("t3_seq%0d", i), seq, tbl[i].seq);
      chk($sformatf("t3_tf%0d", i), tfm, 8'b00000001);
      chk($sformatf("t3_gap%0d", i), gaps, 0);
      chk($sformatf("t3_rowdur%0d", i), rw, tbl[i].row_after - 4'd1);
      chk($sformatf("t3_row%0d", i), row8[0], tbl[i].row_after);
    end

    // test 4: en low for 3 cycles after 4 bits
    din8[0] = 8'h3C; dv8[0] = 1'b1;
    tick();
    dv8[0] = 1'b0;
    tick();
    seq = '0; tfm = '0; nv = 0;
    for (int i = 0; i < 4; i++) begin
      seq = {seq[6:0], dout8[0]};
      tfm = {tfm[6:0], tf8[0]};
      if (dov8[0]) nv++;
      tick();
    end
    snap = {dout8[0], dov8[0], tf8[0]};
    en8[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t4_freeze%0d", i),
          {dout8[0], dov8[0], tf8[0]}, snap);
    end
    en8[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      seq = {seq[6:0], dout8[0]};
      tfm = {tfm[6:0], tf8[0]};
      if (dov8[0]) nv++;
      tick();
    end
    chk("t4_seq", seq, 8'b00111100);
    chk("t4_tf", tfm, 8'b00000001);
    chk("t4_valid_cnt", nv, 8);
    chk("t4_row", {row8[0], dov8[0]}, {4'd5, 1'b0});

    // test 6: reset at bit 30 with a second word in hreg
    a_din = W0; a_dv = 1'b1;
    tick();
    a_din = W3;
    tick();
    tick();
    a_dv = 1'b0;
    for (int i = 1; i < 30; i++) tick();
    chk("t6_pre_state", {a_dov, a_rdy, a_tf}, 3'b100);
    rst = 1'b0;
    #1;
    chk("t6_rst_outs", {a_dout, a_dov, a_tf, a_fe, a_rdy}, 5'b00001);
    chk("t6_rst_row", a_row, 4'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("t6_rdy_after", a_rdy, 1'b1);
    nv = 0;
    for (int i = 0; i < 80; i++) begin
      if (a_dov || a_tf) nv++;
      tick();
    end
    chk("t6_no_output", nv, 0);
    word75(W3, cap, lat, tfbad, gaps, rw);
    chk("t6_bits", cap, W3);
    chk("t6_tflag", tfbad, 0);
    chk("t6_row_during", rw, 4'd0);
    chk("t6_row_after", a_row, 4'd1);

    // test 5: 14-word frame on the 8-bit instance
    chk("t5_row_start", row8[0], 4'd0);
    din8[0] = 8'd1; dv8[0] = 1'b1;
    sent = 0; ntf = 0; fes = 0; fe_at = -1; rowbad = 0;
    for (int c = 0; c < 300 && ntf < 14; c++) begin
      if (tf8[0]) begin
        if (row8[0] != 4'(ntf)) rowbad++;
        if (fe8[0]) begin
          fes++;
          fe_at = ntf;
        end
        ntf++;
      end else if (fe8[0]) begin
        fes++;
      end
      acc = dv8[0] && rdy8[0];
      tick();
      if (acc) begin
        sent++;
        if (sent == 14) dv8[0] = 1'b0;
        else din8[0] = 8'(sent * 17 + 1);
      end
    end
    chk("t5_words", ntf, 14);
    chk("t5_rows", rowbad, 0);
    chk("t5_fe_count", fes, 1);
    chk("t5_fe_word", fe_at, 13);
    chk("t5_row_wrap", {row8[0], dov8[0]}, {4'd0, 1'b0});

    // ROWS=1: row stays 0, frame_end tracks tFlag
    for (int i = 0; i < 2; i++) begin
      word8(1, 8'hC3, seq, tfm, fem, rw, gaps);
      chk($sformatf("r1_seq%0d", i), seq, 8'hC3);
      chk($sformatf("r1_tf%0d", i), tfm, 8'b00000001);
      chk($sformatf("r1_fe%0d", i), fem, 8'b00000001);
      chk($sformatf("r1_row%0d", i), {rw, row8[1]}, 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
